// File: rtl/fetch_queue.sv
// Instruction fetch controller with a DEPTH-entry queue feeding the IF/ID register.
// Optional same-cycle response bypass is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pcplus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ZERO  = (AW + 1)'(0);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic [31:0]    r_instr [DEPTH];
    logic [31:0]    r_pcp4  [DEPTH];

    logic           w_q_pop;
    logic           w_rsp;
    logic           w_bypass;
    logic           w_push;
    logic           w_req;

    // Queue handshake decode: pops, accepted responses and the optional bypass path.
    always_comb begin
        w_q_pop  = 1'b0;
        w_rsp    = 1'b0;
        w_bypass = 1'b0;
        w_push   = 1'b0;
        w_req    = 1'b0;
        if (rst_n) begin
            w_q_pop = (r_count != CNT_ZERO) && out_ready;
            w_rsp   = (r_state == ST_WAIT) && imem_rvalid && !redirect;
`ifdef FETCHQ_BYPASS_EN
            w_bypass = w_rsp && (r_count == CNT_ZERO);
`else
            w_bypass = 1'b0;
`endif
            // A bypassed response consumed directly by IF/ID never occupies a slot.
            w_push  = w_rsp && !(w_bypass && out_ready);
            w_req   = (r_state == ST_IDLE) && !redirect &&
                      ((r_count != CNT_FULL) || w_q_pop);
        end else begin
            w_q_pop  = 1'b0;
            w_rsp    = 1'b0;
            w_bypass = 1'b0;
            w_push   = 1'b0;
            w_req    = 1'b0;
        end
    end

    // Output mux: head entry of the queue, or the live response when bypassing.
    always_comb begin
        out_valid   = 1'b0;
        out_instr   = r_instr[r_rptr];
        out_pcplus4 = r_pcp4[r_rptr];
        if (!rst_n) begin
            out_valid = 1'b0;
        end else if (w_bypass) begin
            out_valid   = 1'b1;
            out_instr   = imem_rdata;
            out_pcplus4 = r_pc;
        end else begin
            out_valid = (r_count != CNT_ZERO);
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign count     = r_count;

    // Fetch controller: request/response sequencing, PC update and stale-response drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= ST_IDLE;
                    end else if (w_req && imem_gnt) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= imem_rvalid ? ST_IDLE : ST_DRAIN;
                    end else if (imem_rvalid) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end else begin
                        r_pc <= r_pc;
                    end
                    r_state <= imem_rvalid ? ST_IDLE : ST_DRAIN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Queue occupancy and pointers; a redirect discards everything including this cycle's push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= CNT_ZERO;
        end else if (redirect) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_q_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end else begin
                r_rptr <= r_rptr;
            end
            case ({w_push, w_q_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; the request PC has already advanced, so r_pc is the entry's PC+4.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wptr] <= imem_rdata;
            r_pcp4[r_wptr]  <= r_pc;
        end else begin
            r_instr[r_wptr] <= r_instr[r_wptr];
            r_pcp4[r_wptr]  <= r_pcp4[r_wptr];
        end
    end

endmodule
